// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 requester.
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb3_state_t;

    localparam int APB3_TIMEOUT_DISABLED = 0;

endpackage

// File: rtl/apb3_wait_timer.sv
// Wait-state watchdog: counts stalled ACCESS cycles and flags the last one allowed.
module apb3_wait_timer
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] count;

    // Saturates so a disabled watchdog never wraps back into a false match.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != APB3_TIMEOUT_DISABLED) && (count == CW'(LIMIT));

endmodule

// File: rtl/apb3_master.sv
// APB3 requester: turns valid/ready commands into single SETUP/ACCESS transfers
// and reports completion, slave error or watchdog timeout as a one-cycle pulse.
module apb3_master
    import apb3_pkg::*;
#(
    parameter int N_BIT_DATA     = 32,
    parameter int N_BIT_ADDRESS  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [N_BIT_ADDRESS-1:0] cmd_addr,
    input  logic [N_BIT_DATA-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    output logic [N_BIT_DATA-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [N_BIT_ADDRESS-1:0] PADDR,
    output logic [N_BIT_DATA-1:0]    PWDATA,
    input  logic [N_BIT_DATA-1:0]    PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    // state  | meaning
    // IDLE   | ready for a command, bus idle
    // SETUP  | PSEL high, PENABLE low, one cycle
    // ACCESS | PSEL and PENABLE high, waiting on PREADY or watchdog

    apb3_state_t state;
    logic        expired;

    apb3_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state == SETUP),
        .count_en((state == ACCESS) && !PREADY),
        .expired (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A completing PREADY wins over a watchdog expiring on the same edge.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        state       <= IDLE;
                    end else if (expired) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    ap_enable_needs_select: assert property (@(posedge PCLK) disable iff (!PRESETn)
        PENABLE |-> PSEL);

    ap_enable_after_setup: assert property (@(posedge PCLK) disable iff (!PRESETn)
        $rose(PENABLE) |-> ($past(PSEL) && !$past(PSEL, 2)));

    ap_select_drops_with_enable: assert property (@(posedge PCLK) disable iff (!PRESETn)
        ($past(PENABLE) && !PENABLE) |-> !PSEL);

endmodule

// File: doc/apb3_master.md
Name: apb3_master

Overview:
- APB3 requester: converts a valid/ready command interface into single APB3 transfers (SETUP then ACCESS phase). Returns read data, error and timeout status as a one-cycle response pulse.
- Sits between an internal controller and an APB3 completer such as apb3_slave. Drives PSEL, PENABLE, PWRITE, PADDR and PWDATA; samples PREADY, PRDATA and PSLVERR.
- Carries a wait-state watchdog so a stuck completer cannot hang the requester.

Parameters:
- N_BIT_DATA, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- N_BIT_ADDRESS, 4, width of PADDR and cmd_addr.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  N_BIT_ADDRESS  transfer address.
- cmd_wdata  in  N_BIT_DATA  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  N_BIT_DATA  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  N_BIT_ADDRESS  APB address.
- PWDATA  out  N_BIT_DATA  APB write data.
- PRDATA  in  N_BIT_DATA  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset values:
  - All outputs are registered and reset to 0, including cmd_ready.
  - State is IDLE.
  - cmd_ready rises after the first rising edge with PRESETn high.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On an edge where cmd_valid&&cmd_ready, capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
  - At the same edge set PSEL=1, cmd_ready=0, and go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Next edge sets PENABLE=1 and goes to ACCESS.
  - The wait counter clears to 0.
- ACCESS, edge with PREADY=1:
  - Transfer completes: PSEL=0, PENABLE=0, cmd_ready=1, rsp_valid=1.
  - rsp_err=PSLVERR, rsp_timeout=0.
  - rsp_rdata=PRDATA for a read, 0 for a write.
  - Next state is IDLE.
- ACCESS, edge with PREADY=0:
  - Counter increments.
  - If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1, abort: PSEL=0, PENABLE=0, cmd_ready=1, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, next state IDLE.
  - ACCESS therefore never exceeds TIMEOUT_CYCLES cycles.
- PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.
- Latency:
  - Zero wait states: command accepted at edge 0, SETUP after edge 0, ACCESS after edge 1, response after edge 2.
  - Each wait state adds one cycle.
  - rsp_valid coincides with cmd_ready=1, so the next command can be accepted at edge 3. Minimum period is 3 cycles per transfer.
- Response:
  - rsp_valid is a single-cycle pulse with no backpressure.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- PADDR, PWRITE and PWDATA:
  - Stable from SETUP through ACCESS.
  - Hold their last values after completion; they are never cleared except by reset.
- cmd_* inputs are don't-care while cmd_ready=0.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It must not wrap inside a transfer.
- Reset mid-transfer: PSEL and PENABLE drop immediately, and no response is emitted for the lost command.
- Protocol invariants (asserted):
  - PENABLE implies PSEL.
  - PENABLE rises only one cycle after PSEL rises.
  - PSEL never stays high across a cycle where PENABLE=0 and the previous cycle had PENABLE=1.

Decomposition:
- Package apb3_pkg holds:
  - typedef enum logic [1:0] apb3_state_t {IDLE, SETUP, ACCESS};
  - localparam APB3_TIMEOUT_DISABLED = 0.
- One sub-module, apb3_wait_timer:
  - Inputs: PCLK, PRESETn, clear, count_en.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES.
- The FSM, capture registers and response logic stay in apb3_master.

Test Plan:
- Write, zero wait: cmd addr=0x3, wdata=0xDEADBEEF, responder with PREADY=1 → PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA=0xDEADBEEF, rsp_valid 2 edges after accept, rsp_err=0, rsp_rdata=0.
- Read, 5 wait states: cmd addr=0xA, responder returns PRDATA=0x12345678 after 5 PREADY=0 cycles → ACCESS lasts 6 cycles, rsp_rdata=0x12345678, rsp_timeout=0.
- Error: read with PREADY=1 and PSLVERR=1 → rsp_err=1, rsp_timeout=0. PSLVERR=1 driven during wait cycles → no effect.
- Timeout: TIMEOUT_CYCLES=16, PREADY stuck at 0 → PSEL/PENABLE drop after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, cmd_ready=1.
- Back-to-back: cmd_valid held high for 4 alternating write/read commands, zero wait → one accept every 3 cycles, 4 rsp_valid pulses in order, PSEL low for 1 cycle between transfers.
- Reset in ACCESS: PRESETn low during a wait state → PSEL, PENABLE and rsp_valid are 0 the same cycle. After release, cmd_ready=1 after one edge and no stale response appears.
